uart_tx_comp: RTL and testbench

UART_TX_COMP -- requirements
Module: uart_tx_comp

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo.sv | 60 ++++++
 rtl/uart_tx_comp.sv | 126 ++++++++++++
 tb/tb_uart_tx_comp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encoding and frame-format defaults.
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;  // s_tick pulses per start/data bit

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with registered empty/full flags, shared by the UART TX and RX paths.
module uart_fifo #(
  parameter int WIDTH  = 8,
  parameter int FIFO_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] r_data,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0]  ram [2**FIFO_W];
  logic [FIFO_W-1:0] w_ptr, r_ptr, w_succ, r_succ;
  logic              wr_en, rd_en;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_en  = rd & ~empty;
  assign wr_en  = wr & (~full | rd_en);
  assign w_succ = w_ptr + 1'b1;
  assign r_succ = r_ptr + 1'b1;
  assign r_data = ram[r_ptr];

  // NOTE: storage is deliberately left out of reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) ram[w_ptr] <= w_data;
  end

  // NOTE: every register here uses <= so all state updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10: begin
          w_ptr <= w_succ;
          empty <= 1'b0;
          full  <= (w_succ == r_ptr);
        end
        2'b01: begin
          r_ptr <= r_succ;
          full  <= 1'b0;
          empty <= (r_succ == w_ptr);
        end
        2'b11: begin
          w_ptr <= w_succ;
          r_ptr <= r_succ;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_comp.sv
// UART transmitter: free-running baud tick generator, 4-deep TX FIFO and a registered-output TX FSM.
module uart_tx_comp
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int DVSR    = 5,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  output logic            tx,
  output logic            s_tick,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int DW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic [DW-1:0]   b_cnt;
  uart_state_e     state;
  logic [DBIT-1:0] shift;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] fifo_data;
  logic            fifo_rd;

  always_ff @(posedge clk) begin
    if (reset)                          b_cnt <= '0;
    else if (b_cnt == DW'(DVSR - 1))    b_cnt <= '0;
    else                                b_cnt <= b_cnt + 1'b1;
  end

  assign s_tick = (b_cnt == DW'(DVSR - 1));

  uart_fifo #(
    .WIDTH  (DBIT),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (fifo_rd),
    .wr     (wr_uart),
    .w_data (w_data),
    .r_data (fifo_data),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  // The pop happens in the single IDLE cycle that hands the head byte to the shifter.
  assign fifo_rd = (state == IDLE) && !tx_empty;
  assign tx_busy = (state != IDLE);

  // tx is assigned alongside each state change so the line level is a flop, never decoded logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tx           <= 1'b1;
      shift        <= '0;
      s_cnt        <= '0;
      n_cnt        <= '0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!tx_empty) begin
            shift <= fifo_data;
            s_cnt <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == SW'(OVERSAMPLE - 1)) begin
              s_cnt <= '0;
              n_cnt <= '0;
              tx    <= shift[0];
              state <= DATA;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == SW'(OVERSAMPLE - 1)) begin
              s_cnt <= '0;
              shift <= {1'b0, shift[DBIT-1:1]};
              if (n_cnt == NW'(DBIT - 1)) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + 1'b1;
                tx    <= shift[1];
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_cnt == SW'(SB_TICK - 1)) begin
              s_cnt        <= '0;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_comp.sv
// Directed bench for uart_tx_comp: a serial-line monitor decodes and times every frame against the UART format.
module tb_uart_tx_comp;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_uart = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       tx, s_tick, tx_full, tx_empty, tx_busy, tx_done_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int tick_bad = 0;
  int idle_bad = 0;
  int tick_since = -1;

  int rx_q[$];
  int fr_start[$];
  int fr_end[$];
  int fr_empty[$];

  uart_tx_comp #(.DBIT(8), .SB_TICK(16), .DVSR(5), .FIFO_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .tx           (tx),
    .s_tick       (s_tick),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Tick period and done-pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (reset) begin
      tick_since = -1;
    end else begin
      if (tick_since >= 0) tick_since++;
      if (s_tick) begin
        if (tick_since >= 0 && tick_since != 5) tick_bad++;
        tick_since = 0;
      end
    end
  end

  // Called on the first falling edge where tx_busy is seen; returns early if reset aborts the frame.
  task automatic mon_frame();
    int n, ticks, viol, len;
    logic [7:0] b;
    n = 0; ticks = 0; viol = 0; b = '0;
    fr_start.push_back(cyc);
    fr_empty.push_back(int'(tx_empty));
    forever begin
      if (reset) return;
      if (tx !== 1'b0 || tx_done_tick) viol++;
      if (s_tick) ticks++;
      if (ticks == 16 || n >= 200) break;
      n++;
      @(negedge clk);
    end
    len = n + 1;
    check("start_len_76_to_80", int'(len >= 76 && len <= 80), 1);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 80; j++) begin
        @(negedge clk);
        if (reset) return;
        if (j == 0) b[i] = tx;
        else if (tx !== b[i]) viol++;
        if (tx_done_tick) viol++;
      end
    end
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (reset) return;
      if (tx !== 1'b1 || tx_done_tick) viol++;
    end
    @(negedge clk);
    if (reset) return;
    check("frame_bit_timing", viol, 0);
    check("done_at_stop_end", int'({tx_done_tick, tx_busy}), 2);
    fr_end.push_back(cyc);
    rx_q.push_back(int'(b));
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_busy) mon_frame();
        else if (tx !== 1'b1) idle_bad++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    wr_uart = 1'b1;
    w_data  = b;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while ((tx_busy || !tx_empty) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, int'(n < limit), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    fr_start.delete();
    fr_end.delete();
    fr_empty.delete();
  endtask

  function automatic int rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : -1;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stimulus
    int lat, n, d0, busy_seen;
    int exp2[5];
    int exp3[6];
    int exp5[3];
    exp2 = '{'hA5, 'h3C, 'hFF, 'h00, 'h81};
    exp3 = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66};
    exp5 = '{'h00, 'hCD, 'hFF};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_empty", int'(tx_empty), 1);
    check("rst_full", int'(tx_full), 0);
    check("rst_done", int'(tx_done_tick), 0);
    check("rst_tick", int'(s_tick), 0);
    reset = 1'b0;

    // Single byte 0xCD: bits 1,0,1,1,0,0,1,1 on the wire
    push(8'hCD);
    lat = 0;
    while (tx && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t1_tx_fall_within_2", int'(lat <= 2), 1);
    wait_idle(1500, "t1");
    check("t1_frame_count", rx_q.size(), 1);
    check("t1_byte", rx_at(0), 'hCD);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_busy_low", int'(tx_busy), 0);
    check("t1_tx_idle_high", int'(tx), 1);

    // Six writes on consecutive cycles: fifth fills, sixth dropped
    clear_logs();
    d0 = done_cnt;
    push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
    check("t2_not_full_after4", int'(tx_full), 0);
    push(8'h81);
    check("t2_full_after5", int'(tx_full), 1);
    push(8'h7E);
    check("t2_full_after_drop", int'(tx_full), 1);
    wait_idle(6000, "t2");
    check("t2_frame_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t2_byte%0d", i), rx_at(i), exp2[i]);
    check("t2_done_pulses", done_cnt - d0, 5);
    for (int i = 0; i < 4; i++)
      if (i + 1 < fr_start.size() && i < fr_end.size())
        check($sformatf("t2_gap%0d", i), fr_start[i+1] - fr_end[i], 1);
    if (fr_empty.size() == 5) begin
      check("t2_empty_at_frame4_start", fr_empty[3], 0);
      check("t2_empty_at_frame5_start", fr_empty[4], 1);
    end

    // Write into a full FIFO in the same cycle as the FSM pop
    clear_logs();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("t3_full", int'(tx_full), 1);
    n = 0;
    while (!tx_done_tick && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t3_done_seen", int'(n < 2000), 1);
    check("t3_full_at_pop", int'(tx_full), 1);
    push(8'h66);
    check("t3_full_after_rw", int'(tx_full), 1);
    check("t3_next_frame_started", int'(tx_busy), 1);
    wait_idle(7000, "t3");
    check("t3_frame_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_byte%0d", i), rx_at(i), exp3[i]);

    // Reset during DATA of 0x55 with three bytes still queued
    clear_logs();
    push(8'h55); push(8'h01); push(8'h02); push(8'h03);
    repeat (300) @(negedge clk);
    check("t4_busy_in_data", int'(tx_busy), 1);
    check("t4_queued", int'(tx_empty), 0);
    reset = 1'b1;
    @(negedge clk);
    check("t4_tx_high", int'(tx), 1);
    check("t4_empty", int'(tx_empty), 1);
    check("t4_full", int'(tx_full), 0);
    check("t4_busy", int'(tx_busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx_busy) busy_seen++;
    end
    check("t4_no_frames_after", busy_seen, 0);
    check("t4_no_bytes", rx_q.size(), 0);
    check("t4_tx_idle", int'(tx), 1);

    // Loopback-style decode of 0x00, 0xCD, 0xFF
    clear_logs();
    push(8'h00); push(8'hCD); push(8'hFF);
    wait_idle(4000, "t5");
    check("t5_frame_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t5_byte%0d", i), rx_at(i), exp5[i]);

    check("tick_period_5", tick_bad, 0);
    check("tx_high_when_idle", idle_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
